// File: rtl/perm_output_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : perm_output_serializer_if
// Purpose  : Bundles the state strobe input and the 200-bit beat output of the
//            permutation output serializer.
// Signals  : pushin/din/tagin   - full 1600-bit state plus tag, one strobe
//            pushout/doutix/dout- beat valid, beat index, beat data
//            tagout             - tag of the state being sent
//            full/overflow      - pending buffer occupied / sticky drop flag
// Modports : master - upstream producer and beat consumer
//            slave  - the serializer itself
// Revision : 1.0 - initial release
// ============================================================================
interface perm_output_serializer_if #(
  parameter int NBEAT = 8,
  parameter int BEATW = 200
);
  logic                     pushin;
  logic [NBEAT*BEATW-1:0]   din;
  logic [7:0]               tagin;
  logic                     pushout;
  logic [2:0]               doutix;
  logic [BEATW-1:0]         dout;
  logic [7:0]               tagout;
  logic                     full;
  logic                     overflow;

  modport master (
    output pushin, din, tagin,
    input  pushout, doutix, dout, tagout, full, overflow
  );

  modport slave (
    input  pushin, din, tagin,
    output pushout, doutix, dout, tagout, full, overflow
  );
endinterface

`default_nettype wire

// File: rtl/perm_output_serializer.sv
`default_nettype none
// ============================================================================
// Module   : perm_output_serializer
// Purpose  : Takes a complete 1600-bit Keccak state plus tag in one strobe and
//            sends it as eight consecutive 200-bit beats. A one-deep pending
//            buffer lets the next state arrive while the current one is sent,
//            so back-to-back states stream without a bubble.
// Ports    : clk    - rising-edge clock
//            reset  - asynchronous active-high reset
//            bus    - perm_output_serializer_if.slave (strobe in, beats out)
// Revision : 1.0 - initial release
// ============================================================================
module perm_output_serializer #(
  parameter int NBEAT = 8,
  parameter int BEATW = 200
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  perm_output_serializer_if.slave    bus
);

  localparam int         c_STATEW = NBEAT * BEATW;
  localparam logic [2:0] c_LAST   = 3'(NBEAT - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t                state_q,      state_d;
  logic [2:0]            cnt_q,        cnt_d;
  logic [c_STATEW-1:0]   act_q,        act_d;
  logic [7:0]            act_tag_q,    act_tag_d;
  logic [c_STATEW-1:0]   pend_q,       pend_d;
  logic [7:0]            pend_tag_q,   pend_tag_d;
  logic                  pend_valid_q, pend_valid_d;
  logic                  ovf_q,        ovf_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      act_q        <= '0;
      act_tag_q    <= '0;
      pend_q       <= '0;
      pend_tag_q   <= '0;
      pend_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      act_q        <= act_d;
      act_tag_q    <= act_tag_d;
      pend_q       <= pend_d;
      pend_tag_q   <= pend_tag_d;
      pend_valid_q <= pend_valid_d;
      ovf_q        <= ovf_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    act_d        = act_q;
    act_tag_d    = act_tag_q;
    pend_d       = pend_q;
    pend_tag_d   = pend_tag_q;
    pend_valid_d = pend_valid_q;
    ovf_d        = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (bus.pushin) begin
          act_d     = bus.din;
          act_tag_d = bus.tagin;
          cnt_d     = '0;
          state_d   = S_SEND;
        end
      end

      S_SEND: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == c_LAST) begin
          // Last beat: the slot frees up this edge, so a push is always
          // accepted here even while the pending buffer is occupied.
          if (pend_valid_q) begin
            act_d        = pend_q;
            act_tag_d    = pend_tag_q;
            cnt_d        = '0;
            pend_valid_d = bus.pushin;
            if (bus.pushin) begin
              pend_d     = bus.din;
              pend_tag_d = bus.tagin;
            end
          end else if (bus.pushin) begin
            act_d     = bus.din;
            act_tag_d = bus.tagin;
            cnt_d     = '0;
          end else begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end else if (bus.pushin) begin
          if (!pend_valid_q) begin
            pend_d       = bus.din;
            pend_tag_d   = bus.tagin;
            pend_valid_d = 1'b1;
          end else begin
            // No room: the new state is dropped and the error latched.
            ovf_d = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Outputs depend on registers only; tagout keeps the last tag while idle.
  assign bus.pushout  = (state_q == S_SEND);
  assign bus.doutix   = (state_q == S_SEND) ? cnt_q : 3'd0;
  assign bus.dout     = (state_q == S_SEND) ? act_q[BEATW*int'(cnt_q) +: BEATW]
                                            : '0;
  assign bus.tagout   = act_tag_q;
  assign bus.full     = pend_valid_q;
  assign bus.overflow = ovf_q;

endmodule

`default_nettype wire
